// File: rtl/alu_mul_seq.sv
// rtl/alu_mul_seq.sv - sequential 64x64 shift-add multiplier (low 64 bits) using a shared external ALU
module alu_mul_seq #(
    parameter logic [2:0] ALU_ADD = 3'b010
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [63:0] mcand,
    input  logic [63:0] mplier,
    output logic        busy,
    output logic        done,
    output logic [63:0] product,
    output logic [63:0] alu_A,
    output logic [63:0] alu_B,
    output logic [2:0]  alu_cntrl,
    input  logic [63:0] alu_result
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state;
    logic [63:0] mcand_r;
    logic [63:0] mplier_r;
    logic [63:0] acc;
    logic [5:0]  count;

    // The ALU is only borrowed while running; it sees zeros otherwise.
    always_comb begin
        alu_A     = 64'h0;
        alu_B     = 64'h0;
        alu_cntrl = 3'b000;
        if (state == RUN) begin
            alu_A     = acc;
            alu_B     = mplier_r[0] ? mcand_r : 64'h0;
            alu_cntrl = ALU_ADD;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            mcand_r  <= 64'h0;
            mplier_r <= 64'h0;
            acc      <= 64'h0;
            count    <= 6'd0;
            product  <= 64'h0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        mcand_r  <= mcand;
                        mplier_r <= mplier;
                        acc      <= 64'h0;
                        count    <= 6'd0;
                        busy     <= 1'b1;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    acc      <= alu_result;
                    mcand_r  <= mcand_r << 1;
                    mplier_r <= mplier_r >> 1;
                    count    <= count + 6'd1;
                    // Always a full 64 steps, even once the multiplier has shifted out to zero.
                    if (count == 6'd63) begin
                        product <= alu_result;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        state   <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_mul_seq.sv
// tb/tb_alu_mul_seq.sv - scoreboard bench for alu_mul_seq with a behavioural shared ALU
module tb_alu_mul_seq;

    localparam logic [2:0] ALU_ADD = 3'b010;

    logic        clk;
    logic        reset;
    logic        start;
    logic [63:0] mcand;
    logic [63:0] mplier;
    logic        busy;
    logic        done;
    logic [63:0] product;
    logic [63:0] alu_A;
    logic [63:0] alu_B;
    logic [2:0]  alu_cntrl;
    logic [63:0] alu_result;

    int n_compared   = 0;
    int n_mismatched = 0;
    int busy_cnt     = 0;
    int done_cnt     = 0;
    logic prev_done  = 1'b0;
    logic [63:0] exp_q[$];

    alu_mul_seq #(.ALU_ADD(ALU_ADD)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .mcand      (mcand),
        .mplier     (mplier),
        .busy       (busy),
        .done       (done),
        .product    (product),
        .alu_A      (alu_A),
        .alu_B      (alu_B),
        .alu_cntrl  (alu_cntrl),
        .alu_result (alu_result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        alu_result = 64'h0;
        case (alu_cntrl)
            3'b000:  alu_result = alu_A & alu_B;
            3'b001:  alu_result = alu_A | alu_B;
            ALU_ADD: alu_result = alu_A + alu_B;
            3'b110:  alu_result = alu_A - alu_B;
            default: alu_result = 64'h0;
        endcase
    end

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_compared++;
        if (obs !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Monitor: counts busy cycles per operation and retires scoreboard entries on done.
    always @(negedge clk) begin
        if (reset) begin
            busy_cnt  = 0;
            prev_done = 1'b0;
        end else begin
            if (busy) busy_cnt++;
            if (done) begin
                logic [63:0] exp_p;
                check_eq("done_single_cycle", {63'h0, prev_done}, 64'h0);
                check_eq("busy_cycles", 64'(busy_cnt), 64'd64);
                if (exp_q.size() == 0) begin
                    check_eq("unexpected_done", 64'h1, 64'h0);
                end else begin
                    exp_p = exp_q.pop_front();
                    check_eq("product", product, exp_p);
                end
                check_eq("busy_in_done", {63'h0, busy}, 64'h0);
                busy_cnt = 0;
                done_cnt++;
            end
            prev_done = done;
        end
    end

    task automatic drive_start(input logic [63:0] a, input logic [63:0] b, input bit expect_run);
        @(negedge clk);
        start  = 1'b1;
        mcand  = a;
        mplier = b;
        if (expect_run) exp_q.push_back(a * b);
        @(negedge clk);
        start  = 1'b0;
        mcand  = 64'h0;
        mplier = 64'h0;
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        while (done !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) check_eq({tag, "_timeout"}, 64'h1, 64'h0);
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    initial begin
        int base;
        reset  = 1'b1;
        start  = 1'b0;
        mcand  = 64'h0;
        mplier = 64'h0;
        idle_cycles(3);
        check_eq("rst_busy", {63'h0, busy}, 64'h0);
        check_eq("rst_done", {63'h0, done}, 64'h0);
        check_eq("rst_product", product, 64'h0);
        check_eq("rst_alu_A", alu_A, 64'h0);
        check_eq("rst_alu_B", alu_B, 64'h0);
        check_eq("rst_alu_cntrl", {61'h0, alu_cntrl}, 64'h0);
        reset = 1'b0;
        idle_cycles(2);

        // Basic 3*5, with a look at the first two ALU requests.
        @(negedge clk);
        start = 1'b1; mcand = 64'd3; mplier = 64'd5;
        exp_q.push_back(64'd15);
        @(negedge clk);
        start = 1'b0; mcand = 64'h0; mplier = 64'h0;
        check_eq("run0_alu_cntrl", {61'h0, alu_cntrl}, {61'h0, ALU_ADD});
        check_eq("run0_alu_A", alu_A, 64'd0);
        check_eq("run0_alu_B", alu_B, 64'd3);
        @(negedge clk);
        check_eq("run1_alu_A", alu_A, 64'd3);
        check_eq("run1_alu_B", alu_B, 64'd0);
        wait_done("basic");
        idle_cycles(2);

        drive_start(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
        wait_done("neg");
        idle_cycles(2);

        drive_start(64'h8000_0000_0000_0001, 64'd2, 1'b1);
        wait_done("wrap");
        idle_cycles(2);

        // Start while busy must be ignored.
        base = done_cnt;
        drive_start(64'd7, 64'd9, 1'b1);
        idle_cycles(8);
        drive_start(64'd2, 64'd2, 1'b0);
        wait_done("busy_restart");
        idle_cycles(80);
        check_eq("no_second_run", 64'(done_cnt - base), 64'd1);
        check_eq("held_63", product, 64'd63);

        // Reset mid-run aborts with no done.
        base = done_cnt;
        drive_start(64'd11, 64'd13, 1'b0);
        idle_cycles(29);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_eq("midrst_busy", {63'h0, busy}, 64'h0);
        check_eq("midrst_done", {63'h0, done}, 64'h0);
        check_eq("midrst_product", product, 64'h0);
        check_eq("midrst_alu_cntrl", {61'h0, alu_cntrl}, 64'h0);
        idle_cycles(70);
        check_eq("midrst_no_done", 64'(done_cnt - base), 64'd0);
        drive_start(64'd4, 64'd4, 1'b1);
        wait_done("after_reset");
        idle_cycles(2);

        // Back-to-back: second start in the IDLE cycle right after done.
        drive_start(64'd6, 64'd7, 1'b1);
        wait_done("b2b_first");
        @(negedge clk);
        start = 1'b1; mcand = 64'd2; mplier = 64'd3;
        exp_q.push_back(64'd6);
        @(negedge clk);
        start = 1'b0; mcand = 64'h0; mplier = 64'h0;
        check_eq("b2b_accepted", {63'h0, busy}, 64'h1);
        idle_cycles(40);
        check_eq("b2b_hold_42", product, 64'd42);
        wait_done("b2b_second");
        idle_cycles(2);

        for (int i = 0; i < 4; i++) begin
            drive_start({$urandom, $urandom}, {$urandom, $urandom}, 1'b1);
            wait_done("random");
            idle_cycles(1);
        end

        idle_cycles(3);
        check_eq("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

// File: doc/alu_mul_seq.md
ALU_MUL_SEQ -- requirements
Module: alu_mul_seq

Interface
REQ-001 The block SHALL have one parameter: ALU_ADD, default 3'b010, the ALU control code that selects result = A + B.
REQ-002 Port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 Port reset, input, 1 bit: synchronous, active-high reset sampled on the rising edge of clk.
REQ-004 Port start, input, 1 bit: request to begin a multiply; sampled only in IDLE.
REQ-005 Port mcand, input, 64 bits: multiplicand; captured when start is accepted.
REQ-006 Port mplier, input, 64 bits: multiplier; captured when start is accepted.
REQ-007 Port busy, output, 1 bit: high while the block is in RUN.
REQ-008 Port done, output, 1 bit: high for exactly one cycle, in DONE.
REQ-009 Port product, output, 64 bits: lower 64 bits of mcand*mplier; valid from done onward.
REQ-010 Port alu_A, output, 64 bits: drives A of the shared 64-bit ALU.
REQ-011 Port alu_B, output, 64 bits: drives B of the shared ALU.
REQ-012 Port alu_cntrl, output, 3 bits: drives the ALU control of the shared ALU.
REQ-013 Port alu_result, input, 64 bits: combinational result of the shared ALU, used in the same cycle.

Function
REQ-014 The block SHALL implement a three-state FSM with states IDLE, RUN and DONE.
REQ-015 In IDLE, start=1 at an edge SHALL do all of the following: latch mcand into mcand_r, latch mplier into mplier_r, clear acc and the 6-bit count, and enter RUN.
REQ-016 In IDLE, start=0 SHALL leave the block in IDLE.
REQ-017 In RUN, the block SHALL drive alu_A=acc, alu_B=(mplier_r[0] ? mcand_r : 64'h0) and alu_cntrl=ALU_ADD.
REQ-018 Each RUN edge SHALL perform acc<=alu_result, mcand_r<=mcand_r<<1 (zero fill), mplier_r<=mplier_r>>1 (logical) and count<=count+1.
REQ-019 RUN SHALL last exactly 64 cycles; the edge at which count==63 SHALL enter DONE, with no early termination when mplier_r becomes 0.
REQ-020 The block SHALL write product<=alu_result on the final RUN edge, then hold product until the next accepted start or reset.
REQ-021 Outputs SHALL be busy=1 only in RUN and done=1 only in DONE; DONE SHALL return to IDLE after one cycle.
REQ-022 start SHALL be ignored in RUN and DONE, with no capture, restart or queuing.
REQ-023 A start in the IDLE cycle immediately after DONE SHALL be accepted.
REQ-024 Latency: if start is accepted at edge N, busy SHALL be high in cycles N+1..N+64 and done SHALL be high in cycle N+65.
REQ-025 Outside RUN, the block SHALL drive alu_A=0, alu_B=0 and alu_cntrl=3'b000.
REQ-026 Arithmetic SHALL be modulo 2^64: carries above bit 63 are discarded, so the result is correct for both signed (two's complement) and unsigned operands.
REQ-027 The block SHALL ignore the ALU flag outputs (negative, zero, overflow, carry_out).

Reset
REQ-028 reset=1 at an edge SHALL force IDLE and clear acc, mcand_r, mplier_r, count and product to 0.
REQ-029 After reset, busy=0 and done=0, and the ALU outputs SHALL take the values given in REQ-025.
REQ-030 reset SHALL take priority over start and over any FSM transition.
REQ-031 Asserting reset mid-RUN SHALL abort the operation with no done pulse.
REQ-032 Outputs SHALL be undefined only before the first reset edge.

Verification
REQ-033 The bench SHALL cover a basic multiply:
- mcand=3, mplier=5, start pulse at edge N;
- busy high for 64 cycles;
- done high in cycle N+65 with product=15.
REQ-034 The bench SHALL cover negative operands:
- mcand=64'hFFFF_FFFF_FFFF_FFFF, mplier=64'hFFFF_FFFF_FFFF_FFFF;
- required result product=1 (-1*-1).
REQ-035 The bench SHALL cover wrap-around:
- mcand=64'h8000_0000_0000_0001, mplier=2;
- required result product=2, with the carry above bit 63 discarded.
REQ-036 The bench SHALL cover start while busy:
- operands 7*9 started, then start re-pulsed at cycle N+10 with operands 2*2;
- required result product=63, done in cycle N+65 only, and no second run.
REQ-037 The bench SHALL cover reset mid-RUN:
- reset at cycle N+30;
- next cycle busy=0, done=0, product=0, alu_cntrl=3'b000;
- a subsequent start of 4*4 SHALL give product=16.
REQ-038 The bench SHALL cover back-to-back operations:
- start 6*7, then start 2*3 in the IDLE cycle after done;
- required results product=42, then product=6, with the 42 held until the second done.
